// File: rtl/keypad_scanner_mmio.sv
// Memory-mapped 4x4 keypad scanner: column sweep, debounced press map and
// a STATUS/DATA/CTRL register window on the CPU data bus.
module keypad_scanner_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0010,
  parameter int          SCAN_DIV  = 50000,
  parameter int          DEBOUNCE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        wen,
  output logic [31:0] data_out,
  output logic        hit,
  output logic [3:0]  cols,
  input  logic [3:0]  rows
);

  localparam int DIVW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNTW = $clog2(DEBOUNCE + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 2);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_EVAL   = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cols;
  logic [1:0]        r_col;
  logic [DIVW-1:0]   r_div;
  logic [CNTW-1:0]   r_cnt;
  logic [15:0]       r_map;
  logic [15:0]       r_prev;
  logic [15:0]       r_stable;
  logic [3:0]        r_rows_s1;
  logic [3:0]        r_rows_s2;
  logic              r_en;
  logic              r_valid;
  logic              r_ovf;
  logic [3:0]        r_data;

  logic              w_sel_status;
  logic              w_sel_data;
  logic              w_sel_ctrl;
  logic              w_w1c;
  logic              w_ctrl_wr;
  logic              w_en_nxt;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic              w_accept;
  logic [15:0]       w_new;
  logic              w_event;
  logic [3:0]        w_code;
  logic              w_unused;

  // Index of the lowest set bit; callers guarantee a nonzero map.
  function automatic logic [3:0] f_lowest(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign w_sel_status = (address == BASE_ADDR);
  assign w_sel_data   = (address == BASE_ADDR + 32'd4);
  assign w_sel_ctrl   = (address == BASE_ADDR + 32'd8);
  assign hit          = w_sel_status | w_sel_data | w_sel_ctrl;
  assign w_w1c        = wen & w_sel_status & data_in[0];
  assign w_ctrl_wr    = wen & w_sel_ctrl;
  assign w_en_nxt     = w_ctrl_wr ? data_in[0] : r_en;
  assign cols         = r_cols;
  assign w_unused     = &{1'b0, data_in[31:1]};

  // Read mux for the register window.
  always_comb begin
    data_out = 32'd0;
    if (w_sel_status) begin
      data_out = {30'd0, r_ovf, r_valid};
    end else if (w_sel_data) begin
      data_out = {28'd0, r_data};
    end else if (w_sel_ctrl) begin
      data_out = {31'd0, r_en};
    end else begin
      data_out = 32'd0;
    end
  end

  // Debounce bookkeeping evaluated at the end of each sweep.
  always_comb begin
    w_cnt_nxt = CNTW'(1);
    if (r_map == r_prev) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_nxt = r_cnt;
      end else begin
        w_cnt_nxt = r_cnt + CNTW'(1);
      end
    end else begin
      w_cnt_nxt = CNTW'(1);
    end
  end

  assign w_accept = (w_cnt_nxt == CNT_MAX);
  assign w_new    = r_map & ~r_stable;
  assign w_event  = (r_state == S_EVAL) & w_en_nxt & w_accept & (|w_new);
  assign w_code   = f_lowest(w_new);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_s1 <= 4'b1111;
      r_rows_s2 <= 4'b1111;
    end else begin
      r_rows_s1 <= rows;
      r_rows_s2 <= r_rows_s1;
    end
  end

  // Column scan FSM; disabling mid-sample drops that sample with the sweep state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_OFF;
      r_cols   <= 4'b1111;
      r_col    <= 2'd0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_map    <= 16'd0;
      r_prev   <= 16'd0;
      r_stable <= 16'd0;
    end else if (!w_en_nxt) begin
      r_state <= S_OFF;
      r_cols  <= 4'b1111;
      r_col   <= 2'd0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_map   <= 16'd0;
      r_prev  <= 16'd0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (r_en) begin
            r_state <= S_DRIVE;
            r_col   <= 2'd0;
            r_div   <= '0;
            r_cols  <= 4'b1110;
          end else begin
            r_state <= S_OFF;
          end
        end
        S_DRIVE: begin
          if (r_div == DIV_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_div <= r_div + DIVW'(1);
          end
        end
        S_SAMPLE: begin
          r_map[{r_col, 2'b00} +: 4] <= ~r_rows_s2;
          if (r_col == 2'd3) begin
            r_state <= S_EVAL;
          end else begin
            r_state <= S_DRIVE;
            r_col   <= r_col + 2'd1;
            r_div   <= '0;
            r_cols  <= ~(4'b0001 << (r_col + 2'd1));
          end
        end
        S_EVAL: begin
          r_cnt  <= w_cnt_nxt;
          r_prev <= r_map;
          if (w_accept) begin
            r_stable <= r_map;
          end else begin
            r_stable <= r_stable;
          end
          r_state <= S_DRIVE;
          r_col   <= 2'd0;
          r_div   <= '0;
          r_cols  <= 4'b1110;
        end
        default: begin
          r_state <= S_OFF;
          r_cols  <= 4'b1111;
        end
      endcase
    end
  end

  // CPU-visible registers; a press event takes priority over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_data  <= 4'd0;
    end else begin
      r_en <= w_en_nxt;
      if (w_event && w_w1c) begin
        r_data  <= w_code;
        r_valid <= 1'b1;
        r_ovf   <= r_valid;
      end else if (w_event) begin
        if (!r_valid) begin
          r_data  <= w_code;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_w1c) begin
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

endmodule
